// File: rtl/sw_accum_pkg.sv
// -----------------------------------------------------------------------------
// sw_accum_pkg
// Shared definitions for the switch accumulator: the debounce FSM state
// encoding and the default values of the top-level parameters.
// No ports (package).
// -----------------------------------------------------------------------------
package sw_accum_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_SUM_W     = 16;
  localparam int DEF_LED_W     = 8;
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_DB_CYCLES = 500000;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

endpackage

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
// Synchronizes and debounces one raw active-low pushbutton and emits a single
// one-cycle press pulse once the button has been stably low for DB_CYCLES.
// Ports:
//   clk_i    in  1  system clock
//   rst_i    in  1  asynchronous active-high reset
//   btnN_i   in  1  raw active-low button, asynchronous and bouncy
//   press_o  out 1  one-cycle pulse on the PRESS_WAIT->HELD transition
// -----------------------------------------------------------------------------
module sw_debounce
  import sw_accum_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btnN_i,
  output logic press_o
);

  localparam int            CW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  db_state_t     state_q;
  db_state_t     state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Two-flop synchronizer. Resets to the released level so that a button
  // already held low when reset lifts is seen as a fresh press.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btnN_i;
      sync2_q <= sync1_q;
    end
  end

  // FSM state and stability counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. The counter only runs while waiting for stability and
  // falls back to zero in every other situation, so any bounce restarts the
  // window. The press pulse is combinational on the qualifying cycle so the
  // accumulator can act on the very edge that moves the FSM into HELD.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    press_o = 1'b0;
    case (state_q)
      RELEASED: begin
        if (!sync2_q) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (sync2_q) begin
          state_d = RELEASED;
        end else if (cnt_q == LAST) begin
          state_d = HELD;
          press_o = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (sync2_q) state_d = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (!sync2_q) begin
          state_d = HELD;
        end else if (cnt_q == LAST) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

endmodule

// File: rtl/sw_accum.sv
// -----------------------------------------------------------------------------
// sw_accum
// Adds a switch operand into an accumulator on each debounced press of the
// Accumulate button, clears on the Clear button, and counts accepted presses.
// Optional macro SW_ACCUM_SAT_EN: saturate at all-ones instead of wrapping.
// Ports:
//   Clk           in  1       system clock
//   Reset         in  1       asynchronous active-high reset
//   SW            in  DATA_W  switch operand (asynchronous)
//   Accumulate_n  in  1       raw active-low accumulate button
//   Clear_n       in  1       raw active-low clear button
//   Sum           out SUM_W   accumulator value
//   LED           out LED_W   low bits of Sum
//   Overflow      out 1       sticky carry-out / saturation flag
//   Count         out CNT_W   accepted accumulate presses, wrapping
// -----------------------------------------------------------------------------
module sw_accum
  import sw_accum_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int SUM_W     = DEF_SUM_W,
  parameter int LED_W     = DEF_LED_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] SW,
  input  logic              Accumulate_n,
  input  logic              Clear_n,
  output logic [SUM_W-1:0]  Sum,
  output logic [LED_W-1:0]  LED,
  output logic              Overflow,
  output logic [CNT_W-1:0]  Count
);

  logic [DATA_W-1:0] swSync1_q;
  logic [DATA_W-1:0] swSync2_q;
  logic              accPress;
  logic              clrPress;
  logic [SUM_W-1:0]  sum_q;
  logic [SUM_W-1:0]  sum_d;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              ovf_q;
  logic              ovf_d;
  logic [SUM_W:0]    addFull;

  // Operand synchronizer; it has the same depth as the button paths so the
  // operand is settled long before any press can be accepted.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      swSync1_q <= '1;
      swSync2_q <= '1;
    end else begin
      swSync1_q <= SW;
      swSync2_q <= swSync1_q;
    end
  end

  sw_debounce #(.DB_CYCLES(DB_CYCLES)) uAccDebounce (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .btnN_i  (Accumulate_n),
    .press_o (accPress)
  );

  sw_debounce #(.DB_CYCLES(DB_CYCLES)) uClrDebounce (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .btnN_i  (Clear_n),
    .press_o (clrPress)
  );

  // One extra bit captures the carry-out of the zero-extended addition.
  assign addFull = {1'b0, sum_q} + (SUM_W+1)'(swSync2_q);

  // Datapath update. Clear has priority over a simultaneous accumulate.
  always_comb begin
    sum_d   = sum_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clrPress) begin
      sum_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (accPress) begin
`ifdef SW_ACCUM_SAT_EN
      if (addFull[SUM_W]) begin
        sum_d = '1;
        ovf_d = 1'b1;
      end else begin
        sum_d = addFull[SUM_W-1:0];
      end
`else
      sum_d = addFull[SUM_W-1:0];
      if (addFull[SUM_W]) ovf_d = 1'b1;
`endif
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sum_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Sum      = sum_q;
  assign LED      = sum_q[LED_W-1:0];
  assign Overflow = ovf_q;
  assign Count    = count_q;

endmodule

// File: tb/tb_sw_accum.sv
// -----------------------------------------------------------------------------
// tb_sw_accum
// Directed, table-driven bench for sw_accum with DB_CYCLES=4, DATA_W=8,
// SUM_W=8. Expected values follow SW_ACCUM_SAT_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_sw_accum;

  localparam int DATA_W = 8;
  localparam int SUM_W  = 8;
  localparam int LED_W  = 8;
  localparam int CNT_W  = 8;
  localparam int DB     = 4;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [DATA_W-1:0] SW;
  logic              Accumulate_n;
  logic              Clear_n;
  logic [SUM_W-1:0]  Sum;
  logic [LED_W-1:0]  LED;
  logic              Overflow;
  logic [CNT_W-1:0]  Count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       doClear;
    logic [7:0] sw;
    logic [7:0] expSum;
    logic [7:0] expCount;
    logic       expOvf;
  } vec_t;

  vec_t vecs [10];

  sw_accum #(
    .DATA_W(DATA_W), .SUM_W(SUM_W), .LED_W(LED_W), .CNT_W(CNT_W), .DB_CYCLES(DB)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .SW           (SW),
    .Accumulate_n (Accumulate_n),
    .Clear_n      (Clear_n),
    .Sum          (Sum),
    .LED          (LED),
    .Overflow     (Overflow),
    .Count        (Count)
  );

  always #5 Clk = ~Clk;

  task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expSum,
                             input logic [7:0] expCount, input logic expOvf);
    checkOne({tag, " Sum"},      32'(Sum),      32'(expSum));
    checkOne({tag, " LED"},      32'(LED),      32'(expSum));
    checkOne({tag, " Count"},    32'(Count),    32'(expCount));
    checkOne({tag, " Overflow"}, 32'(Overflow), 32'(expOvf));
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic applyStimulus(input logic doClear, input logic [7:0] sw);
    if (doClear) begin
      Clear_n = 1'b0;
      waitCycles(12);
      Clear_n = 1'b1;
      waitCycles(12);
    end else begin
      SW = sw;
      waitCycles(3);
      Accumulate_n = 1'b0;
      waitCycles(12);
      Accumulate_n = 1'b1;
      waitCycles(12);
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'h05, 8'h05, 8'd1, 1'b0};
    vecs[1] = '{1'b0, 8'h10, 8'h15, 8'd2, 1'b0};
    vecs[2] = '{1'b0, 8'h2A, 8'h3F, 8'd3, 1'b0};
`ifdef SW_ACCUM_SAT_EN
    vecs[3] = '{1'b0, 8'hF0, 8'hFF, 8'd4, 1'b1};
    vecs[4] = '{1'b0, 8'h01, 8'hFF, 8'd5, 1'b1};
`else
    vecs[3] = '{1'b0, 8'hF0, 8'h2F, 8'd4, 1'b1};
    vecs[4] = '{1'b0, 8'h01, 8'h30, 8'd5, 1'b1};
`endif
    vecs[5] = '{1'b1, 8'h00, 8'h00, 8'd0, 1'b0};
    vecs[6] = '{1'b0, 8'hFF, 8'hFF, 8'd1, 1'b0};
`ifdef SW_ACCUM_SAT_EN
    vecs[7] = '{1'b0, 8'hFF, 8'hFF, 8'd2, 1'b1};
`else
    vecs[7] = '{1'b0, 8'hFF, 8'hFE, 8'd2, 1'b1};
`endif
    vecs[8] = '{1'b1, 8'h00, 8'h00, 8'd0, 1'b0};
    vecs[9] = '{1'b0, 8'h20, 8'h20, 8'd1, 1'b0};

    Reset        = 1'b1;
    SW           = '0;
    Accumulate_n = 1'b1;
    Clear_n      = 1'b1;
    waitCycles(2);
    checkOutput("reset", 8'h00, 8'd0, 1'b0);
    Reset = 1'b0;
    waitCycles(3);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].doClear, vecs[i].sw);
      checkOutput($sformatf("vec%0d", i), vecs[i].expSum, vecs[i].expCount, vecs[i].expOvf);
    end

    // Exact latency of a clean press, and no repeat while held.
    applyStimulus(1'b1, 8'h00);
    SW = 8'h05;
    waitCycles(3);
    Accumulate_n = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      @(posedge Clk);
      #1;
      checkOne($sformatf("latency edge%0d Sum", e), 32'(Sum), (e < 7) ? 32'h0 : 32'h5);
    end
    waitCycles(100);
    checkOutput("held100", 8'h05, 8'd1, 1'b0);
    Accumulate_n = 1'b1;
    waitCycles(12);

    // Bouncing button: short lows never qualify, the final stable low does once.
    applyStimulus(1'b1, 8'h00);
    SW = 8'h11;
    waitCycles(3);
    for (int t = 0; t < 6; t++) begin
      Accumulate_n = t[0];
      waitCycles(2);
    end
    Accumulate_n = 1'b0;
    waitCycles(20);
    checkOutput("bounce", 8'h11, 8'd1, 1'b0);
    Accumulate_n = 1'b1;
    waitCycles(12);
    checkOutput("bounceRel", 8'h11, 8'd1, 1'b0);

    // Clear and accumulate pressed together: clear wins.
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b0, 8'h20);
    checkOutput("preBoth", 8'h20, 8'd1, 1'b0);
    Accumulate_n = 1'b0;
    Clear_n      = 1'b0;
    waitCycles(12);
    checkOutput("both", 8'h00, 8'd0, 1'b0);
    Accumulate_n = 1'b1;
    Clear_n      = 1'b1;
    waitCycles(12);

    // Asynchronous reset mid-press clears outputs without a clock edge.
    applyStimulus(1'b0, 8'h07);
    checkOutput("preRst", 8'h07, 8'd1, 1'b0);
    Accumulate_n = 1'b0;
    waitCycles(3);
    #3 Reset = 1'b1;
    #1 checkOutput("asyncRst", 8'h00, 8'd0, 1'b0);
    Accumulate_n = 1'b1;
    waitCycles(3);
    Reset = 1'b0;
    waitCycles(12);
    checkOutput("postRst", 8'h00, 8'd0, 1'b0);

    // Reset two cycles into PRESS_WAIT with the button held through reset.
    SW = 8'h09;
    waitCycles(3);
    Accumulate_n = 1'b0;
    waitCycles(5);
    Reset = 1'b1;
    waitCycles(3);
    checkOutput("inRst", 8'h00, 8'd0, 1'b0);
    Reset = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      @(posedge Clk);
      #1;
      checkOne($sformatf("rstHold edge%0d Sum", e), 32'(Sum), (e < 7) ? 32'h0 : 32'h9);
    end
    waitCycles(20);
    checkOutput("rstHold", 8'h09, 8'd1, 1'b0);
    Accumulate_n = 1'b1;
    waitCycles(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sw_accum.md
SW_ACCUM -- requirements
Module: sw_accum

Interface
REQ-001 Parameter DATA_W, default 8: width of switch operand.
REQ-002 Parameter SUM_W, default 16: accumulator width; SUM_W >= DATA_W.
REQ-003 Parameter LED_W, default 8: LED width; LED_W <= SUM_W.
REQ-004 Parameter CNT_W, default 8: accumulation-event counter width.
REQ-005 Parameter DB_CYCLES, default 500000: debounce stability window in clocks; >= 1.
REQ-006 Clk  in  1  system clock; all state is rising-edge.
REQ-007 Reset  in  1  asynchronous, active-high reset.
REQ-008 SW  in  DATA_W  switch operand; asynchronous to Clk.
REQ-009 Accumulate_n  in  1  raw active-low pushbutton; asynchronous and bouncy.
REQ-010 Clear_n  in  1  raw active-low pushbutton; asynchronous and bouncy.
REQ-011 Sum  out  SUM_W  accumulator value.
REQ-012 LED  out  LED_W  Sum[LED_W-1:0].
REQ-013 Overflow  out  1  sticky carry-out flag.
REQ-014 Count  out  CNT_W  number of accepted accumulate presses, modulo 2^CNT_W.

Function
REQ-015 SW, Accumulate_n and Clear_n SHALL each pass through a two-flop synchronizer before use.
REQ-016 Each button SHALL be debounced by a four-state FSM: RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-017 RELEASED->PRESS_WAIT on synchronized low; PRESS_WAIT->HELD after DB_CYCLES consecutive low cycles; any high in PRESS_WAIT returns to RELEASED and zeroes the counter.
REQ-018 HELD->RELEASE_WAIT on synchronized high; RELEASE_WAIT->RELEASED after DB_CYCLES consecutive high cycles; any low returns to HELD.
REQ-019 Debouncer SHALL emit a one-cycle press pulse on the PRESS_WAIT->HELD transition only; holding a button SHALL produce exactly one pulse.
REQ-020 On an accumulate pulse, Sum SHALL be updated on the next edge: Sum <= Sum + zero-extended synchronized SW; Count increments, wrapping modulo 2^CNT_W.
REQ-021 Latency: Sum changes DB_CYCLES+3 edges after the first edge that samples Accumulate_n low, given no bounce.
REQ-022 Addition SHALL wrap modulo 2^SUM_W; a carry-out SHALL set Overflow, which stays set until clear or reset.
REQ-023 On a clear pulse, Sum, Count and Overflow SHALL go to 0 on the next edge.
REQ-024 Clear and accumulate pulses in the same cycle: clear SHALL win; Count is not incremented.
REQ-025 LED SHALL be a combinational slice of the Sum register, so it carries no extra latency.

Reset
REQ-026 Reset SHALL force Sum=0, LED=0, Overflow=0, Count=0, both FSMs to RELEASED, debounce counters to 0 and synchronizers to 1.
REQ-027 Reset asserted mid-press SHALL abort the press with no update.
REQ-028 A button still held low after reset deasserts SHALL produce exactly one press after DB_CYCLES.

Configuration
REQ-029 With SW_ACCUM_SAT_EN defined, addition SHALL saturate at all-ones, and Overflow SHALL still be set whenever saturation occurs.
REQ-030 Without SW_ACCUM_SAT_EN, addition SHALL wrap per REQ-022.

Structure
REQ-031 Package sw_accum_pkg SHALL hold the debounce state enum (db_state_t) and the default parameter constants.
REQ-032 Sub-module sw_debounce (synchronizer, FSM, counter, press pulse) SHALL be instantiated once per button.

Verification (bench uses DB_CYCLES=4, DATA_W=8)
REQ-033 Reset pulse during arbitrary activity -> Sum=0, LED=0, Overflow=0, Count=0 immediately, asynchronously.
REQ-034 SW=8'h05, clean press held for 100 cycles -> Sum=5 exactly 7 edges after press, Count=1, no further change while held.
REQ-035 Accumulate_n toggling every 2 cycles for 12 cycles, then stable low -> exactly one add; Count=1.
REQ-036 SUM_W=8, SW=8'hFF, two presses -> Sum=8'hFE and Overflow=1; with SW_ACCUM_SAT_EN, Sum=8'hFF and Overflow=1.
REQ-037 Sum=8'h20, then accumulate and clear pulses in the same cycle -> Sum=0, Count=0, Overflow=0.
REQ-038 Reset asserted 2 cycles into PRESS_WAIT with the button held -> no add during reset; exactly one add DB_CYCLES+3 edges after release of Reset.
